// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle for sync_fifo_flags.
// The master side writes and reads the FIFO; the slave side is the FIFO itself.
interface sync_fifo_flags_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 150
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO of arbitrary depth with occupancy count, threshold flags,
// sticky overflow/underflow and a synchronous flush.
module sync_fifo_flags #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 150,
  parameter int unsigned AF_THRESH = 146,
  parameter int unsigned AE_THRESH = 4
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_flags_if.slave bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic full, empty;
  logic wr_acc, rd_acc;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Acceptance is masked by flush so a flush cycle never touches storage.
  assign wr_acc = bus.wr_en & ~full  & ~bus.flush;
  assign rd_acc = bus.rd_en & ~empty & ~bus.flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (bus.wr_en && full)  overflow_d  = 1'b1;
      if (bus.rd_en && empty) underflow_d = 1'b1;

      if (wr_acc) begin
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr_d   = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        rd_data_d  = mem[rd_ptr_q];
        rd_valid_d = 1'b1;
      end

      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; contents are only observable after a fresh write.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CNT_W'(AE_THRESH));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomized and directed bench for sync_fifo_flags against a queue-based
// reference model of the FIFO's externally visible behaviour.
module tb_sync_fifo_flags;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 150;
  localparam int unsigned AF     = 146;
  localparam int unsigned AE     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sync_fifo_flags_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sync_fifo_flags #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_data  = '0;
  logic              m_valid = 1'b0;
  logic              m_ovf   = 1'b0;
  logic              m_unf   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = mq.size();
    check("count",        32'(bus.count),        32'(sz));
    check("full",         32'(bus.full),         32'(sz == DEPTH));
    check("empty",        32'(bus.empty),        32'(sz == 0));
    check("almost_full",  32'(bus.almost_full),  32'(sz >= AF));
    check("almost_empty", 32'(bus.almost_empty), 32'(sz <= AE));
    check("overflow",     32'(bus.overflow),     32'(m_ovf));
    check("underflow",    32'(bus.underflow),    32'(m_unf));
    check("rd_valid",     32'(bus.rd_valid),     32'(m_valid));
    check("rd_data",      32'(bus.rd_data),      32'(m_data));
  endtask

  task automatic model_reset();
    mq.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // One clock: apply inputs, advance the model, compare everything.
  task automatic step(input logic w, input logic r, input logic f, input logic [DATA_W-1:0] d);
    logic was_full, was_empty;
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.flush   = f;
    bus.wr_data = d;
    @(posedge clk);
    #1;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (f) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_valid = 1'b0;
    end else begin
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_unf = 1'b1;
      m_valid = r && !was_empty;
      if (m_valid) m_data = mq.pop_front();
      if (w && !was_full) mq.push_back(d);
    end
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    bus.wr_data = '0;
    #12;
    rst = 1'b0;
    model_reset();
    check_all();

    // Fill 0x00..0x95, then one write while full.
    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 1'b0, 1'b0, 8'(i));
    step(1'b1, 1'b0, 1'b0, 8'hAA);
    for (int i = 0; i < int'(DEPTH); i++) step(1'b0, 1'b1, 1'b0, '0);
    idle();

    // Wrap across the last index.
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 101; i++) step(1'b0, 1'b1, 1'b0, '0);

    // Empty with both enables, then read the word back.
    step(1'b1, 1'b1, 1'b0, 8'h5A);
    step(1'b0, 1'b1, 1'b0, '0);
    idle();

    // Full with both enables, then half-full streaming.
    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    step(1'b1, 1'b1, 1'b0, 8'h77);
    while (mq.size() > 75) step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom));

    // Flush with overflow set and both enables asserted.
    step(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < int'(DEPTH) + 1; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    step(1'b1, 1'b1, 1'b1, 8'hC3);
    idle();

    // Random traffic with alternating bias so both boundaries are visited.
    for (int blk = 0; blk < 8; blk++) begin
      int unsigned wp, rp;
      wp = (blk % 2 == 0) ? 75 : 30;
      rp = (blk % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 400; i++) begin
        step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
             $urandom_range(0, 199) == 0, 8'($urandom));
      end
    end

    // Asynchronous reset in the middle of a burst, checked before the next edge.
    for (int i = 0; i < 12; i++) step(1'b1, i > 4, 1'b0, 8'($urandom));
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    #2;
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
